spi_master: RTL and testbench

Mode-0 SPI master that drives the FPGA's SPI slave port (or any mode-0 slave) from a byte-stream interface: MSB first, one or more bytes per chip-select frame, full duplex. It sits between on-chip logic or a test sequencer and the `sclk`/`cs`/`mosi`/`miso` pins. It is also the bench-side driver for loopback testing of the slave. SCLK is derived from `clk` by a programmable half-period divider.

---
 rtl/spi_master_if.sv | 29 ++
 rtl/spi_master.sv | 148 ++++++++++++++
 tb/tb_spi_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_master_if : byte-stream handshake plus SPI pin bundle           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface spi_master_if;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       sclk;
   logic       cs;
   logic       mosi;
   logic       miso;

   modport master (
      input  tx_data, tx_last, tx_valid, miso,
      output tx_ready, rx_data, rx_valid, busy, sclk, cs, mosi
   );

   modport slave (
      output tx_data, tx_last, tx_valid, miso,
      input  tx_ready, rx_data, rx_valid, busy, sclk, cs, mosi
   );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_master : mode-0 SPI master, MSB first, multi-byte CS frames     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module spi_master #(
   parameter int CLK_DIV = 8
) (
   input  logic         clk,
   input  logic         rst,
   spi_master_if.master bus
);

   localparam int             HCW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [HCW-1:0] HC_MAX = HCW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD  = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_NEXT  = 3'd4,
      S_TRAIL = 3'd5,
      S_GAP   = 3'd6
   } state_t;

   state_t         state_q;
   logic [HCW-1:0] hc_q;
   logic [2:0]     bc_q;
   logic [6:0]     tx_sh_q;
   logic [7:0]     rx_sh_q;
   logic [7:0]     rx_data_q;
   logic           last_q;
   logic           rx_valid_q;
   logic           sclk_q;
   logic           cs_q;
   logic           mosi_q;
   logic           miso_meta_q;
   logic           miso_sync_q;

   logic           tx_ready;
   logic           accept;
   logic           hc_done;

   assign tx_ready = (state_q == S_IDLE) || (state_q == S_NEXT);
   assign accept   = bus.tx_valid && tx_ready;
   assign hc_done  = (hc_q == HC_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hc_q        <= '0;
         bc_q        <= '0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         last_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         sclk_q      <= 1'b0;
         cs_q        <= 1'b1;
         mosi_q      <= 1'b0;
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
      end else begin
         miso_meta_q <= bus.miso;
         miso_sync_q <= miso_meta_q;
         rx_valid_q  <= 1'b0;

         case (state_q)
            // IDLE and NEXT accept identically; NEXT simply keeps CS low.
            S_IDLE, S_NEXT: begin
               hc_q <= '0;
               if (accept) begin
                  tx_sh_q <= bus.tx_data[6:0];
                  last_q  <= bus.tx_last;
                  cs_q    <= 1'b0;
                  mosi_q  <= bus.tx_data[7];
                  bc_q    <= '0;
                  state_q <= S_LEAD;
               end
            end

            S_LEAD, S_LOW: begin
               if (hc_done) begin
                  hc_q    <= '0;
                  sclk_q  <= 1'b1;
                  rx_sh_q <= {rx_sh_q[6:0], miso_sync_q};
                  state_q <= S_HIGH;
               end else begin
                  hc_q <= hc_q + 1'b1;
               end
            end

            S_HIGH: begin
               if (hc_done) begin
                  hc_q   <= '0;
                  sclk_q <= 1'b0;
                  if (bc_q != 3'd7) begin
                     bc_q    <= bc_q + 3'd1;
                     mosi_q  <= tx_sh_q[6];
                     tx_sh_q <= {tx_sh_q[5:0], 1'b0};
                     state_q <= S_LOW;
                  end else begin
                     rx_data_q  <= rx_sh_q;
                     rx_valid_q <= 1'b1;
                     state_q    <= last_q ? S_TRAIL : S_NEXT;
                  end
               end else begin
                  hc_q <= hc_q + 1'b1;
               end
            end

            S_TRAIL: begin
               if (hc_done) begin
                  hc_q    <= '0;
                  cs_q    <= 1'b1;
                  mosi_q  <= 1'b0;
                  state_q <= S_GAP;
               end else begin
                  hc_q <= hc_q + 1'b1;
               end
            end

            // Minimum CS-high time before the next frame may start.
            S_GAP: begin
               if (hc_done) begin
                  hc_q    <= '0;
                  state_q <= S_IDLE;
               end else begin
                  hc_q <= hc_q + 1'b1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.tx_ready = tx_ready;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.sclk     = sclk_q;
   assign bus.cs       = cs_q;
   assign bus.mosi     = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_master : directed scoreboard bench, D=8 and D=12 instances   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_spi_master;

   logic clk = 1'b0;
   logic rst;
   int   miso_mode;

   always #5 clk = ~clk;

   spi_master_if ifa ();
   spi_master_if ifb ();

   spi_master #(.CLK_DIV(8))  dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
   spi_master #(.CLK_DIV(12)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

   // Mode-0 echo slave: returns the previous byte it received, 0x00 first.
   logic [7:0] sl_tx;
   logic [7:0] sl_rx;
   int         sl_cnt;
   logic       sl_sclk_p;
   logic       sl_cs_p;

   always @(posedge clk) begin
      if (rst) begin
         sl_tx <= 8'h00; sl_rx <= 8'h00; sl_cnt <= 0; sl_sclk_p <= 1'b0; sl_cs_p <= 1'b1;
      end else begin
         sl_sclk_p <= ifa.sclk;
         sl_cs_p   <= ifa.cs;
         if (sl_cs_p && !ifa.cs) begin
            sl_tx <= 8'h00; sl_cnt <= 0;
         end else if (!sl_sclk_p && ifa.sclk) begin
            sl_rx <= {sl_rx[6:0], ifa.mosi}; sl_cnt <= sl_cnt + 1;
         end else if (sl_sclk_p && !ifa.sclk) begin
            if (sl_cnt == 8) begin sl_cnt <= 0; sl_tx <= sl_rx; end
            else sl_tx <= {sl_tx[6:0], 1'b0};
         end
      end
   end

   assign ifa.miso = (miso_mode == 1) ? sl_tx[7] : ifa.mosi;
   assign ifb.miso = 1'b1;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic a_bits[$];
   int   a_exp_rx[$];
   int   b_exp_rx[$];
   int   a_next_rx;
   int   a_acc, a_accepts, a_rises, a_rxv, a_rxv_cyc, a_cs_rises, a_cs_rise_cyc, a_rdy_cyc, a_edge_cyc;
   int   b_acc, b_accepts, b_rxv, b_rxv_cyc, b_cs_rise_cyc, b_edge_cyc, b_phases;
   logic a_sclk_p, a_cs_p, a_rdy_p, a_phase_ok;
   logic b_sclk_p, b_cs_p, b_phase_ok;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mon_a();
      int e;
      if (rst) a_phase_ok = 1'b0;
      if (a_cs_p && !ifa.cs) begin a_edge_cyc = cyc; a_phase_ok = !rst; end
      if (!a_cs_p && ifa.cs) begin a_cs_rises++; a_cs_rise_cyc = cyc; end
      if (!a_rdy_p && ifa.tx_ready) a_rdy_cyc = cyc;
      if (!a_sclk_p && ifa.sclk) begin
         a_rises++;
         check("a_bit_pending", a_bits.size() > 0, 1);
         if (a_bits.size() > 0) check("a_mosi_bit", ifa.mosi, a_bits.pop_front());
         if (a_phase_ok) check("a_low_len_ge8", (cyc - a_edge_cyc) >= 8, 1);
         a_edge_cyc = cyc;
      end
      if (a_sclk_p && !ifa.sclk) begin
         if (a_phase_ok) check("a_high_len", cyc - a_edge_cyc, 8);
         a_edge_cyc = cyc;
      end
      if (ifa.rx_valid) begin
         a_rxv++;
         a_rxv_cyc = cyc;
         check("a_rx_pending", a_exp_rx.size() > 0, 1);
         if (a_exp_rx.size() > 0) begin
            e = a_exp_rx.pop_front();
            if (e >= 0) check("a_rx_data", ifa.rx_data, e);
         end
      end
      a_sclk_p = ifa.sclk; a_cs_p = ifa.cs; a_rdy_p = ifa.tx_ready;
   endtask

   task automatic mon_b();
      if (rst) b_phase_ok = 1'b0;
      if (b_cs_p && !ifb.cs) begin b_edge_cyc = cyc; b_phase_ok = !rst; end
      if (!b_cs_p && ifb.cs) b_cs_rise_cyc = cyc;
      if (b_sclk_p != ifb.sclk) begin
         if (b_phase_ok) begin
            check(ifb.sclk ? "b_low_len" : "b_high_len", cyc - b_edge_cyc, 12);
            b_phases++;
         end
         b_edge_cyc = cyc;
      end
      if (ifb.rx_valid) begin
         b_rxv++;
         b_rxv_cyc = cyc;
         check("b_rx_pending", b_exp_rx.size() > 0, 1);
         if (b_exp_rx.size() > 0) check("b_rx_data", ifb.rx_data, b_exp_rx.pop_front());
      end
      b_sclk_p = ifb.sclk; b_cs_p = ifb.cs;
   endtask

   // Inputs are driven at the falling edge; an accept is recorded for the
   // rising edge that follows, then outputs are checked at the next falling edge.
   task automatic step();
      if (!rst && ifa.tx_valid && ifa.tx_ready) begin
         a_acc = cyc; a_accepts++;
         for (int i = 7; i >= 0; i--) a_bits.push_back(ifa.tx_data[i]);
         a_exp_rx.push_back(a_next_rx);
      end
      if (!rst && ifb.tx_valid && ifb.tx_ready) begin
         b_acc = cyc; b_accepts++;
         b_exp_rx.push_back(32'hFF);
      end
      @(negedge clk);
      cyc++;
      mon_a();
      mon_b();
   endtask

   task automatic send(input int which, input logic [7:0] d, input logic l, input int exp_rx);
      int  n0;
      bit  done;
      done = 1'b0;
      if (which == 0) begin
         ifa.tx_data = d; ifa.tx_last = l; ifa.tx_valid = 1'b1; a_next_rx = exp_rx; n0 = a_accepts;
      end else begin
         ifb.tx_data = d; ifb.tx_last = l; ifb.tx_valid = 1'b1; n0 = b_accepts;
      end
      for (int i = 0; i < 600 && !done; i++) begin
         step();
         done = (which == 0) ? (a_accepts != n0) : (b_accepts != n0);
      end
      check("send_accepted", done, 1);
   endtask

   task automatic wait_idle(input int which);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 800 && !idle; i++) begin
         step();
         idle = (which == 0) ? !ifa.busy : !ifb.busy;
      end
      check("wait_idle", idle, 1);
      repeat (3) step();
   endtask

   initial begin
      int r0, c0, v0;
      bit got, bad;
      rst = 1'b1; miso_mode = 0;
      ifa.tx_data = 8'h00; ifa.tx_last = 1'b0; ifa.tx_valid = 1'b0;
      ifb.tx_data = 8'h00; ifb.tx_last = 1'b0; ifb.tx_valid = 1'b0;
      a_next_rx = 0; a_accepts = 0; a_rises = 0; a_rxv = 0; a_cs_rises = 0; a_phase_ok = 1'b0;
      a_acc = 0; a_rxv_cyc = 0; a_cs_rise_cyc = 0; a_rdy_cyc = 0; a_edge_cyc = 0;
      b_acc = 0; b_accepts = 0; b_rxv = 0; b_rxv_cyc = 0; b_cs_rise_cyc = 0; b_edge_cyc = 0; b_phases = 0;
      a_sclk_p = 1'b0; a_cs_p = 1'b1; a_rdy_p = 1'b1; b_sclk_p = 1'b0; b_cs_p = 1'b1; b_phase_ok = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst_cs", ifa.cs, 1);
      check("rst_sclk", ifa.sclk, 0);
      check("rst_mosi", ifa.mosi, 0);
      check("rst_rx_valid", ifa.rx_valid, 0);
      check("rst_rx_data", ifa.rx_data, 8'h00);
      check("rst_busy", ifa.busy, 0);
      check("rst_tx_ready", ifa.tx_ready, 1);
      rst = 1'b0;
      repeat (3) step();

      // Single-byte loopback with exact frame timing
      r0 = a_rises; v0 = a_rxv;
      send(0, 8'hA5, 1'b1, 8'hA5);
      ifa.tx_valid = 1'b0;
      wait_idle(0);
      check("t1_rises", a_rises - r0, 8);
      check("t1_rxv_count", a_rxv - v0, 1);
      check("t1_rxv_time", a_rxv_cyc - a_acc, 129);
      check("t1_cs_rise_time", a_cs_rise_cyc - a_acc, 137);
      check("t1_ready_time", a_rdy_cyc - a_acc, 145);

      // Three-byte frame with tx_valid held high
      r0 = a_rises; v0 = a_rxv; c0 = a_cs_rises;
      send(0, 8'h3C, 1'b0, 8'h3C);
      send(0, 8'h00, 1'b0, 8'h00);
      send(0, 8'hFF, 1'b1, 8'hFF);
      ifa.tx_valid = 1'b0;
      wait_idle(0);
      check("t3_rises", a_rises - r0, 24);
      check("t3_rxv_count", a_rxv - v0, 3);
      check("t3_cs_rises", a_cs_rises - c0, 1);

      // Echo slave: responses are ??, 0x48, 0x69
      miso_mode = 1; v0 = a_rxv;
      send(0, 8'h48, 1'b0, -1);
      send(0, 8'h69, 1'b0, 8'h48);
      send(0, 8'h00, 1'b1, 8'h69);
      ifa.tx_valid = 1'b0;
      wait_idle(0);
      check("echo_rxv_count", a_rxv - v0, 3);
      miso_mode = 0;

      // Stall in NEXT for 50 cycles
      v0 = a_rxv; c0 = a_cs_rises;
      send(0, 8'h5A, 1'b0, 8'h5A);
      ifa.tx_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         step();
         got = (a_rxv != v0);
      end
      check("stall_first_rxv", got, 1);
      check("stall_ready_with_rxv", ifa.tx_ready, 1);
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (ifa.cs !== 1'b0 || ifa.sclk !== 1'b0 || ifa.tx_ready !== 1'b1) bad = 1'b1;
      end
      check("stall_hold", bad, 0);
      send(0, 8'hC3, 1'b1, 8'hC3);
      ifa.tx_valid = 1'b0;
      wait_idle(0);
      check("stall_rxv_count", a_rxv - v0, 2);
      check("stall_cs_rises", a_cs_rises - c0, 1);

      // Reset at the 4th rising edge of a frame
      r0 = a_rises; v0 = a_rxv;
      send(0, 8'hE7, 1'b1, 8'hE7);
      ifa.tx_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         step();
         got = (a_rises == r0 + 4);
      end
      check("rst_mid_reached", got, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_cs", ifa.cs, 1);
      check("rst_mid_sclk", ifa.sclk, 0);
      check("rst_mid_mosi", ifa.mosi, 0);
      check("rst_mid_ready", ifa.tx_ready, 1);
      a_bits.delete();
      a_exp_rx.delete();
      repeat (3) step();
      rst = 1'b0;
      repeat (150) step();
      check("rst_mid_no_rxv", a_rxv - v0, 0);
      send(0, 8'h96, 1'b1, 8'h96);
      ifa.tx_valid = 1'b0;
      wait_idle(0);
      check("rst_after_rxv", a_rxv - v0, 1);

      // D=12 instance, MISO tied high
      b_phases = 0; v0 = b_rxv;
      send(1, 8'h81, 1'b1, 8'hFF);
      ifb.tx_valid = 1'b0;
      wait_idle(1);
      check("b_rxv_count", b_rxv - v0, 1);
      check("b_phases", b_phases, 16);
      check("b_rxv_time", b_rxv_cyc - b_acc, 193);
      check("b_cs_rise_time", b_cs_rise_cyc - b_acc, 205);

      check("a_bits_drained", a_bits.size(), 0);
      check("a_rx_drained", a_exp_rx.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
